// File: rtl/xheep_fpga_ctrl_pkg.sv
// Shared types for the X-HEEP FPGA run controller.
// Holds the run FSM encoding, counter width and hold-counter sizing helper.
package xheep_fpga_ctrl_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } run_state_e;

  function automatic int hold_cnt_width(input int hold_cycles);
    return (hold_cycles <= 2) ? 1 : $clog2(hold_cycles);
  endfunction

endpackage

// File: rtl/xheep_fpga_sync.sv
// Multi-stage flip-flop synchroniser for one asynchronous level, resets to 0.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronised).
module xheep_fpga_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/xheep_fpga_run_ctrl.sv
// Board run controller: sequences x_heep reset and boot straps, then reports exit/timeout.
// Ports: clk_i/rst_ni, async requests, exit_valid/value in; sys reset, straps, status out.
module xheep_fpga_run_ctrl
  import xheep_fpga_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int STRAP_SETUP_CYCLES = 4,
  parameter int TIMEOUT_CYCLES     = 0,
  parameter int SYNC_STAGES        = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_req_i,
  input  logic             boot_select_cfg_i,
  input  logic             exec_flash_cfg_i,
  input  logic             exit_valid_i,
  input  logic [31:0]      exit_value_i,
  output logic             sys_rst_no,
  output logic             boot_select_o,
  output logic             execute_from_flash_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic [31:0]      exit_code_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [1:0]       state_o
);

  localparam int HW = hold_cnt_width(RST_HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(RST_HOLD_CYCLES - 1);
  localparam logic [HW-1:0] STRAP_END =
    HW'(RST_HOLD_CYCLES - STRAP_SETUP_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  logic req, bs, ef;

  xheep_fpga_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req (
    .clk(clk_i), .rst_n(rst_ni), .d(run_req_i), .q(req)
  );
  xheep_fpga_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bs (
    .clk(clk_i), .rst_n(rst_ni), .d(boot_select_cfg_i), .q(bs)
  );
  xheep_fpga_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ef (
    .clk(clk_i), .rst_n(rst_ni), .d(exec_flash_cfg_i), .q(ef)
  );

  run_state_e       state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      code_q, code_d;
  logic done_q, done_d;
  logic pass_q, pass_d;
  logic tmo_q, tmo_d;
  logic boot_q, boot_d;
  logic flash_q, flash_d;
  logic srst_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    done_d  = done_q;
    pass_d  = pass_q;
    tmo_d   = tmo_q;
    boot_d  = boot_q;
    flash_d = flash_q;
    unique case (state_q)
      ST_HOLD: begin
        // straps follow the board only until the setup window starts
        if (hold_q < STRAP_END) begin
          boot_d  = bs;
          flash_d = ef;
        end
        if (req) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (exit_valid_i) begin
          code_d  = exit_value_i;
          done_d  = 1'b1;
          pass_d  = (exit_value_i == 32'd0);
          state_d = ST_DONE;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          tmo_d   = 1'b1;
          state_d = ST_TIMEOUT;
        end
      end
      ST_DONE, ST_TIMEOUT: begin
      end
    endcase
    // a request from any active state restarts the reset sequence
    if (req && state_q != ST_HOLD) begin
      state_d = ST_HOLD;
      hold_d  = '0;
      cnt_d   = '0;
      code_d  = '0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      tmo_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_HOLD;
      hold_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
      boot_q  <= 1'b0;
      flash_q <= 1'b0;
      srst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      boot_q  <= boot_d;
      flash_q <= flash_d;
      srst_q  <= (state_d != ST_HOLD);
    end
  end

  assign sys_rst_no           = srst_q;
  assign boot_select_o        = boot_q;
  assign execute_from_flash_o = flash_q;
  assign done_o               = done_q;
  assign pass_o               = pass_q;
  assign timeout_o            = tmo_q;
  assign exit_code_o          = code_q;
  assign cycle_count_o        = cnt_q;
  assign state_o              = state_q;

endmodule
